add_seq_arb: RTL and testbench



---
 rtl/add_seq_arb.sv | 190 +++++++++++++++++++
 tb/tb_add_seq_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_arb.sv
// Shared 32-bit adder: round-robin arbiter in front of a single 16-bit
// ripple-carry slice that is sequenced low half then high half.
module add_seq_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [HW-1:0]   sum_lo_q, sum_lo_d;
  logic            carry_lo_q, carry_lo_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;

  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];
  logic            found_c;
  logic [IDW-1:0]  win_c;
  logic [IDW-1:0]  cand_c;
  logic [NREQ-1:0] req_ready_c;

  logic [HW-1:0]   slice_a, slice_b, slice_sum;
  logic            slice_cin, slice_cout;
  logic [HW:0]     carry;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DW +: DW];
    assign b_arr[g] = req_b[g*DW +: DW];
  end

  // Round-robin search starting one past the last winner, wrapping upward.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_c = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!found_c && req_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (!rst && state_q == S_IDLE && found_c) begin
      req_ready_c[win_c] = 1'b1;
    end
  end

  assign req_ready = req_ready_c;

  // Operand mux onto the one physical slice.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    case (state_q)
      S_LO: begin
        slice_a = a_q[HW-1:0];
        slice_b = b_q[HW-1:0];
      end
      S_HI: begin
        slice_a   = a_q[DW-1:HW];
        slice_b   = b_q[DW-1:HW];
        slice_cin = carry_lo_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    carry     = '0;
    slice_sum = '0;
    carry[0]  = slice_cin;
    for (int unsigned i = 0; i < HW; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ carry[i];
      carry[i+1]   = (slice_a[i] & slice_b[i]) | (carry[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  assign slice_cout = carry[HW];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_lo_d     = sum_lo_q;
    carry_lo_d   = carry_lo_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          last_grant_d = win_c;
          id_d         = win_c;
          a_d          = a_arr[win_c];
          b_d          = b_arr[win_c];
          state_d      = S_LO;
        end
      end
      S_LO: begin
        sum_lo_d   = slice_sum;
        carry_lo_d = slice_cout;
        state_d    = S_HI;
      end
      // Result registers only update on the edge into RESP.
      S_HI: begin
        rsp_sum_d   = {slice_sum, sum_lo_q};
        rsp_cout_d  = slice_cout;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_lo_q     <= '0;
      carry_lo_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_lo_q     <= sum_lo_d;
      carry_lo_q   <= carry_lo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_add_seq_arb.sv
// Scoreboard bench for add_seq_arb: per-requester operand queues drive the
// arbiter; a transaction-level model predicts grants, timing and results.
module tb_add_seq_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_sum;
  logic                rsp_cout;

  always #5 clk = ~clk;

  add_seq_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  int              cyc      = 0;
  bit              busy     = 1'b0;
  int              acc_cyc  = 0;
  int              ptr      = NREQ - 1;
  logic [34:0]     exp_q[$];
  logic [34:0]     last_resp = '0;
  logic [NREQ-1:0] acc_mask  = '0;
  int              id_log[$];

  // Stimulus state.
  logic [63:0]     opq [NREQ][$];
  bit              drop_mode = 1'b0;
  bit              rr_rand   = 1'b0;
  logic            rr_fixed  = 1'b1;

  function automatic int rr_win(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_FFFF;
      3:       return 32'hFFFF_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: checks every cycle against the model, scoreboard pop on handshake.
  always @(negedge clk) begin
    int              w;
    logic [NREQ-1:0] exp_rdy;
    logic [32:0]     s;
    cyc++;
    if (rst) begin
      chk("req_ready_in_reset", 64'(req_ready), 64'd0);
      busy      = 1'b0;
      ptr       = NREQ - 1;
      exp_q.delete();
      last_resp = '0;
      acc_mask  = '0;
    end else begin
      w       = rr_win(req_valid, ptr);
      exp_rdy = '0;
      if (!busy && w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(busy && (cyc >= acc_cyc + 3)));
      acc_mask = req_valid & req_ready;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual id=%0d sum=%0h required no response (t=%0t)",
                   rsp_id, rsp_sum, $time);
        end else begin
          chk("rsp_result", 64'({rsp_id, rsp_sum, rsp_cout}), 64'(exp_q[0]));
          if (rsp_ready) begin
            last_resp = exp_q.pop_front();
            busy      = 1'b0;
            id_log.push_back(int'(rsp_id));
          end
        end
      end else begin
        chk("rsp_hold", 64'({rsp_id, rsp_sum, rsp_cout}), 64'(last_resp));
      end
      if (!busy && w >= 0 && acc_mask[w]) begin
        s = {1'b0, req_a[32*w +: 32]} + {1'b0, req_b[32*w +: 32]};
        exp_q.push_back({IDW'(w), s[31:0], s[32]});
        busy    = 1'b1;
        acc_cyc = cyc;
        ptr     = w;
      end
    end
  end

  // One clock of stimulus: retire accepted operands, present the next ones.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i] && opq[i].size() > 0) void'(opq[i].pop_front());
      if (opq[i].size() > 0) begin
        req_valid[i]      = drop_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        req_a[32*i +: 32] = opq[i][0][63:32];
        req_b[32*i +: 32] = opq[i][0][31:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy || rsp_valid || opq[0].size() > 0 || opq[1].size() > 0 ||
           opq[2].size() > 0 || opq[3].size() > 0) begin
      step();
      n++;
      if (n > 3000) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout: actual still busy after %0d cycles required idle", n);
        break;
      end
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input int exp);
    if (id_log.size() <= idx) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: actual %0d responses required more than %0d", nm, id_log.size(), idx);
    end else begin
      chk(nm, 64'(id_log[idx]), 64'(exp));
    end
  endtask

  initial begin
    int exp_ids[6];
    int n;
    exp_ids = '{0, 1, 2, 3, 0, 1};
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id",    64'(rsp_id),    64'd0);
    chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("reset_rsp_cout",  64'(rsp_cout),  64'd0);
    rst = 1'b0;

    // Carry crossing the half boundary
    opq[0].push_back({32'h0000_FFFF, 32'h0000_0001});
    drain();
    chk("dir_carry_sum",  64'(rsp_sum),  64'h0001_0000);
    chk("dir_carry_cout", 64'(rsp_cout), 64'd0);
    chk("dir_carry_id",   64'(rsp_id),   64'd0);

    // Full wrap, then a no-carry pattern, both from requester 1
    opq[1].push_back({32'hFFFF_FFFF, 32'h0000_0001});
    opq[1].push_back({32'h1234_5678, 32'h8765_4321});
    drain();
    chk("dir_pat_sum",  64'(rsp_sum),  64'h9999_9999);
    chk("dir_pat_cout", 64'(rsp_cout), 64'd0);
    chk("dir_pat_id",   64'(rsp_id),   64'd1);

    // All requesters valid from reset: strict rotation
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 6; k++) opq[i].push_back({rop(), rop()});
    repeat (2) step();
    rst = 1'b0;
    id_log.delete();
    drain();
    for (int k = 0; k < 6; k++) chk_log("rr_order", k, exp_ids[k]);

    // Backpressure in RESP with another requester pending
    rr_fixed = 1'b0;
    opq[3].push_back({rop(), rop()});
    opq[1].push_back({rop(), rop()});
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk("bp_reached_resp", 64'(rsp_valid), 64'd1);
    repeat (5) step();
    rr_fixed  = 1'b1;
    rsp_ready = 1'b1;
    drain();

    // Reset while the slice is on the high half
    opq[1].push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    n = 0;
    while (n < 50) begin
      step();
      n++;
      if (acc_mask[1]) break;
    end
    step();
    rst = 1'b1;
    opq[2].push_back({rop(), rop()});
    opq[0].push_back({rop(), rop()});
    step();
    rst = 1'b0;
    chk("rst_abort_valid", 64'(rsp_valid), 64'd0);
    chk("rst_abort_sum",   64'(rsp_sum),   64'd0);
    id_log.delete();
    drain();
    chk_log("rst_first_grant",  0, 0);
    chk_log("rst_second_grant", 1, 2);

    // Requester 2 alone, back-to-back random operands
    id_log.delete();
    for (int k = 0; k < 20; k++) opq[2].push_back({$urandom, $urandom});
    drain();
    chk("solo_count", 64'(id_log.size()), 64'd20);

    // Mixed random traffic with dropping valids and random backpressure
    drop_mode = 1'b1;
    rr_rand   = 1'b1;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 15; k++) opq[i].push_back({rop(), rop()});
    repeat (200) step();
    drop_mode = 1'b0;
    rr_rand   = 1'b0;
    rr_fixed  = 1'b1;
    drain();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
